// File: rtl/mul_datapath_pkg.sv
// Shared definitions for the repeated-addition multiplier:
// default width, control-strobe bundle order and FSM state constants.
package mul_datapath_pkg;

    localparam int DEF_WIDTH = 8;

    // Strobe bit order {ld_a, ld_b, ld_p, dec, clr}
    localparam int CTL_LD_A = 4;
    localparam int CTL_LD_B = 3;
    localparam int CTL_LD_P = 2;
    localparam int CTL_DEC  = 1;
    localparam int CTL_CLR  = 0;
    localparam int CTL_BITS = 5;

    typedef struct packed {
        logic ld_a;
        logic ld_b;
        logic ld_p;
        logic dec;
        logic clr;
    } ctrl_t;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    function automatic logic proto_viol(ctrl_t c, logic uflow);
        return uflow | (c.ld_b & c.dec) | (c.clr & c.ld_p);
    endfunction

endpackage

// File: rtl/mul_datapath_if.sv
// Control/status bundle between the multiplier FSM (master)
// and its datapath (slave).
interface mul_datapath_if
    import mul_datapath_pkg::*;
#(
    parameter int W = DEF_WIDTH
);
    logic [W-1:0]   data_in;
    logic           ld_a;
    logic           ld_b;
    logic           ld_p;
    logic           dec;
    logic           clr;
    logic           eqz;
    logic [2*W-1:0] product;
    logic           ovf;
    logic           proto_err;

    modport master (
        output data_in, ld_a, ld_b, ld_p, dec, clr,
        input  eqz, product, ovf, proto_err
    );

    modport slave (
        input  data_in, ld_a, ld_b, ld_p, dec, clr,
        output eqz, product, ovf, proto_err
    );
endinterface

// File: rtl/mul_down_counter.sv
// Loadable down-counter that saturates at zero; flags a decrement
// requested while already at zero.
module mul_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic         dec,
    input  logic [W-1:0] din,
    output logic [W-1:0] q,
    output logic         zero,
    output logic         underflow_attempt
);
    logic [W-1:0] cnt_q;

    assign q                 = cnt_q;
    assign zero              = (cnt_q == '0);
    assign underflow_attempt = dec & ~ld & zero;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (ld) begin
            cnt_q <= din;
        end else if (dec && !zero) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end
endmodule

// File: rtl/mul_datapath.sv
// Datapath of the repeated-addition multiplier: multiplicand A,
// down-counter B and 2W-bit accumulator P with sticky status flags.
module mul_datapath
    import mul_datapath_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    mul_datapath_if.slave bus
);
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] p_q;
    logic               ovf_q;
    logic               perr_q;
    logic [WIDTH-1:0]   b_q;
    logic               b_zero;
    logic               b_uflow;
    logic [2*WIDTH:0]   sum;
    ctrl_t              ctl;

    assign ctl = '{
        ld_a: bus.ld_a,
        ld_b: bus.ld_b,
        ld_p: bus.ld_p,
        dec:  bus.dec,
        clr:  bus.clr
    };

    // Extra top bit captures the carry-out of the 2W-bit add
    assign sum = {1'b0, p_q} + {{(WIDTH+1){1'b0}}, a_q};

    mul_down_counter #(
        .W(WIDTH)
    ) u_b_cnt (
        .clk               (clk),
        .rst               (rst),
        .ld                (ctl.ld_b),
        .dec               (ctl.dec),
        .din               (bus.data_in),
        .q                 (b_q),
        .zero              (b_zero),
        .underflow_attempt (b_uflow)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q    <= '0;
            p_q    <= '0;
            ovf_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            if (ctl.ld_a) begin
                a_q <= bus.data_in;
            end
            if (ctl.clr) begin
                p_q   <= '0;
                ovf_q <= 1'b0;
            end else if (ctl.ld_p) begin
                p_q   <= sum[2*WIDTH-1:0];
                ovf_q <= ovf_q | sum[2*WIDTH];
            end
            if (proto_viol(ctl, b_uflow)) begin
                perr_q <= 1'b1;
            end
        end
    end

    assign bus.eqz       = (b_q == '0) & b_zero;
    assign bus.product   = p_q;
    assign bus.ovf       = ovf_q;
    assign bus.proto_err = perr_q;
endmodule

// File: tb/tb_mul_datapath.sv
// Self-checking bench for mul_datapath: directed scenarios plus
// random strobes compared against an arithmetic reference model.
module tb_mul_datapath;
    import mul_datapath_pkg::*;

    localparam int W   = 8;
    localparam int MOD = 1 << (2 * W);

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int errors = 0;

    int unsigned m_a, m_b, m_p;
    bit m_ovf, m_perr;

    always #5 clk = ~clk;

    mul_datapath_if #(.W(W)) bus ();

    mul_datapath #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model(bit r, bit la, bit lb, bit lp, bit dc, bit cl,
                         int unsigned d);
        int unsigned na, nb, np;
        if (!r) begin
            m_a = 0; m_b = 0; m_p = 0; m_ovf = 0; m_perr = 0;
            return;
        end
        na = m_a; nb = m_b; np = m_p;
        if (la) na = d;
        if (lb) begin
            nb = d;
            if (dc) m_perr = 1;
        end else if (dc) begin
            if (m_b == 0) m_perr = 1;
            else nb = m_b - 1;
        end
        if (cl) begin
            np = 0;
            m_ovf = 0;
            if (lp) m_perr = 1;
        end else if (lp) begin
            np = m_p + m_a;
            if (np >= MOD) begin
                m_ovf = 1;
                np = np - MOD;
            end
        end
        m_a = na; m_b = nb; m_p = np;
    endtask

    task automatic cyc(bit r, bit la, bit lb, bit lp, bit dc, bit cl,
                       int unsigned d);
        @(negedge clk);
        rst         = r;
        bus.ld_a    = la;
        bus.ld_b    = lb;
        bus.ld_p    = lp;
        bus.dec     = dc;
        bus.clr     = cl;
        bus.data_in = d[W-1:0];
        @(posedge clk);
        model(r, la, lb, lp, dc, cl, d % (1 << W));
        #1;
        check("product", 64'(bus.product), 64'(m_p));
        check("eqz", 64'(bus.eqz), 64'(m_b == 0));
        check("ovf", 64'(bus.ovf), 64'(m_ovf));
        check("proto_err", 64'(bus.proto_err), 64'(m_perr));
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.data_in = '0;
        bus.ld_a = 0; bus.ld_b = 0; bus.ld_p = 0;
        bus.dec = 0; bus.clr = 0;

        cyc(0, 0, 0, 0, 0, 0, 0);
        check("rst_prod", 64'(bus.product), 0);
        check("rst_eqz", 64'(bus.eqz), 1);
        check("rst_ovf", 64'(bus.ovf), 0);
        check("rst_perr", 64'(bus.proto_err), 0);

        // Normal multiply 17 * 5
        cyc(1, 1, 0, 0, 0, 0, 17);
        cyc(1, 0, 1, 0, 0, 1, 5);
        check("t1_eqz_load", 64'(bus.eqz), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 1, 1, 0, 0);
            if (i < 4) check("t1_eqz_loop", 64'(bus.eqz), 0);
        end
        check("t1_prod", 64'(bus.product), 85);
        check("t1_eqz", 64'(bus.eqz), 1);
        check("t1_ovf", 64'(bus.ovf), 0);
        check("t1_perr", 64'(bus.proto_err), 0);

        // Zero operand
        cyc(1, 1, 0, 0, 0, 0, 200);
        cyc(1, 0, 1, 0, 0, 1, 0);
        check("t2_eqz", 64'(bus.eqz), 1);
        check("t2_prod", 64'(bus.product), 0);

        // Maximum operands
        cyc(1, 1, 0, 0, 0, 0, 255);
        cyc(1, 0, 1, 0, 0, 1, 255);
        for (int i = 0; i < 255; i++) cyc(1, 0, 0, 1, 1, 0, 0);
        check("t3_prod", 64'(bus.product), 65025);
        check("t3_eqz", 64'(bus.eqz), 1);
        check("t3_ovf", 64'(bus.ovf), 0);

        // Overflow
        cyc(1, 1, 0, 0, 0, 0, 255);
        cyc(1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 258; i++) cyc(1, 0, 0, 1, 0, 0, 0);
        check("t4_prod", 64'(bus.product), 254);
        check("t4_ovf", 64'(bus.ovf), 1);
        cyc(1, 0, 0, 0, 0, 1, 0);
        check("t4_clr_prod", 64'(bus.product), 0);
        check("t4_clr_ovf", 64'(bus.ovf), 0);
        check("t4_perr", 64'(bus.proto_err), 0);

        // Protocol error: dec with B == 0
        cyc(1, 0, 0, 0, 1, 0, 0);
        check("t5a_eqz", 64'(bus.eqz), 1);
        check("t5a_perr", 64'(bus.proto_err), 1);
        cyc(1, 1, 1, 0, 0, 0, 3);
        idle();
        check("t5a_sticky", 64'(bus.proto_err), 1);

        // Protocol error: clr + ld_p with P = 40
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 40);
        cyc(1, 0, 0, 1, 0, 0, 0);
        check("t5b_p40", 64'(bus.product), 40);
        check("t5b_perr0", 64'(bus.proto_err), 0);
        cyc(1, 0, 0, 1, 0, 1, 0);
        check("t5b_prod", 64'(bus.product), 0);
        check("t5b_perr", 64'(bus.proto_err), 1);

        // Protocol error: ld_b + dec, load wins
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 1, 0, 9);
        check("t5c_perr", 64'(bus.proto_err), 1);
        for (int i = 0; i < 9; i++) begin
            check("t5c_eqz_pre", 64'(bus.eqz), 0);
            cyc(1, 0, 0, 0, 1, 0, 0);
        end
        check("t5c_eqz", 64'(bus.eqz), 1);
        check("t5c_sticky", 64'(bus.proto_err), 1);

        // Reset mid-operation, strobes asserted during reset
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 17);
        cyc(1, 0, 1, 0, 0, 1, 5);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 1, 0, 0);
        check("t6_mid", 64'(bus.product), 51);
        cyc(0, 1, 1, 1, 0, 0, 99);
        check("t6_prod", 64'(bus.product), 0);
        check("t6_eqz", 64'(bus.eqz), 1);
        check("t6_ovf", 64'(bus.ovf), 0);
        check("t6_perr", 64'(bus.proto_err), 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        check("t6_a_zero", 64'(bus.product), 0);

        // Random strobes
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(49) != 0,
                $urandom_range(3) == 0, $urandom_range(4) == 0,
                $urandom_range(1) == 0, $urandom_range(1) == 0,
                $urandom_range(7) == 0, $urandom_range(255));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
